// File: rtl/fma_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fma_arb_pkg : shared types, constants and arbitration helper for fma_arb
// Rev 1.0
// ---------------------------------------------------------------------------
package fma_arb_pkg;

  localparam int NREQ       = 2;
  localparam int CTL_W      = 5;
  localparam int FLG_W      = 5;
  localparam int DEF_FLEN   = 64;
  localparam int DEF_LAT    = 4;
  localparam int DEF_QDEPTH = 4;

  typedef enum logic [1:0] {
    OP_FMADD  = 2'd0,
    OP_FMSUB  = 2'd1,
    OP_FNMSUB = 2'd2,
    OP_FNMADD = 2'd3
  } fma_op_e;

  typedef struct packed {
    fma_op_e    op;
    logic [2:0] frm;
  } fma_ctl_t;

  // last_idx is the requester granted most recently; on a tie the other wins
  function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] elig,
                                               input logic            last_idx);
    rr_grant = '0;
    if (elig[0] && (!elig[1] || last_idx)) begin
      rr_grant = 2'b01;
    end else if (elig[1]) begin
      rr_grant = 2'b10;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/fma_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fma_arb_if : request, FMA-unit and response signals of the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface fma_arb_if
  import fma_arb_pkg::*;
#(
  parameter int FLEN = fma_arb_pkg::DEF_FLEN
);

  logic     [NREQ-1:0]            req_valid;
  logic     [NREQ-1:0]            req_ready;
  logic     [NREQ-1:0][FLEN-1:0]  req_x;
  logic     [NREQ-1:0][FLEN-1:0]  req_y;
  logic     [NREQ-1:0][FLEN-1:0]  req_z;
  fma_ctl_t [NREQ-1:0]            req_ctl;
  logic     [NREQ-1:0]            flush;

  logic                           fma_issue;
  logic     [FLEN-1:0]            fma_x;
  logic     [FLEN-1:0]            fma_y;
  logic     [FLEN-1:0]            fma_z;
  fma_ctl_t                       fma_ctl;
  logic     [FLEN-1:0]            fma_res;
  logic     [FLG_W-1:0]           fma_flg;

  logic     [NREQ-1:0]            rsp_valid;
  logic     [NREQ-1:0]            rsp_ready;
  logic     [NREQ-1:0][FLEN-1:0]  rsp_res;
  logic     [NREQ-1:0][FLG_W-1:0] rsp_flg;

  modport master (
    output req_valid, req_x, req_y, req_z, req_ctl, flush, fma_res, fma_flg, rsp_ready,
    input  req_ready, fma_issue, fma_x, fma_y, fma_z, fma_ctl, rsp_valid, rsp_res, rsp_flg
  );

  modport slave (
    input  req_valid, req_x, req_y, req_z, req_ctl, flush, fma_res, fma_flg, rsp_ready,
    output req_ready, fma_issue, fma_x, fma_y, fma_z, fma_ctl, rsp_valid, rsp_res, rsp_flg
  );

endinterface
`default_nettype wire

// File: rtl/fma_arb_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fma_arb_fifo : per-requester result queue with synchronous clear
// Rev 1.0
// ---------------------------------------------------------------------------
module fma_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 69
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_en;
  logic             pop_en;

  assign push_en = push_i & ~clr_i;
  assign pop_en  = pop_i & valid_o & ~clr_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_en) wr_d = wr_q + 1'b1;
      if (pop_en)  rd_d = rd_q + 1'b1;
      if (push_en && !pop_en) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!push_en && pop_en) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_q] <= din_i;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign dout_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fma_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fma_arb : round-robin, credit-based arbiter for one shared pipelined FMA unit
// Rev 1.0
// ---------------------------------------------------------------------------
module fma_arb
  import fma_arb_pkg::*;
#(
  parameter int FLEN   = DEF_FLEN,
  parameter int LAT    = DEF_LAT,
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic     clk,
  input  logic     reset_n,
  fma_arb_if.slave bus
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int DW = FLEN + FLG_W;

  logic [NREQ-1:0]           elig;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           credit;
  logic [NREQ-1:0]           exit_hit;
  logic [NREQ-1:0]           push;
  logic [NREQ-1:0]           pop;
  logic [NREQ-1:0]           rsp_v;
  logic [NREQ-1:0][CW-1:0]   qcnt;
  logic [NREQ-1:0][CW-1:0]   infl_q, infl_d;
  logic [NREQ-1:0][DW-1:0]   dout;
  logic [NREQ-1:0][FLEN-1:0] rsp_res_w;
  logic [NREQ-1:0][FLG_W-1:0] rsp_flg_w;
  logic                      last_q, last_d;
  logic [LAT-1:0]            pv_q, pv_d;
  logic [LAT-1:0]            pid_q, pid_d;

  // Outstanding work (in the pipe or queued) may never exceed the queue depth
  always_comb begin
    credit = '0;
    for (int r = 0; r < NREQ; r++) begin
      credit[r] = (({1'b0, infl_q[r]} + {1'b0, qcnt[r]}) < SW'(QDEPTH));
    end
  end

  always_comb begin
    elig  = bus.req_valid & ~bus.flush & credit;
    grant = '0;
    if (reset_n) begin
      grant = rr_grant(elig, last_q);
    end
    last_d = (|grant) ? grant[1] : last_q;
  end

  assign bus.req_ready = grant;
  assign bus.fma_issue = |grant;
  assign bus.fma_x     = grant[1] ? bus.req_x[1]   : bus.req_x[0];
  assign bus.fma_y     = grant[1] ? bus.req_y[1]   : bus.req_y[0];
  assign bus.fma_z     = grant[1] ? bus.req_z[1]   : bus.req_z[0];
  assign bus.fma_ctl   = grant[1] ? bus.req_ctl[1] : bus.req_ctl[0];

  // Stage LAT-1 is the op issued LAT cycles ago, aligned with fma_res/fma_flg
  always_comb begin
    pv_d  = '0;
    pid_d = '0;
    for (int s = LAT - 1; s > 0; s--) begin
      pv_d[s]  = pv_q[s-1];
      pid_d[s] = pid_q[s-1];
    end
    pv_d[0]  = |grant;
    pid_d[0] = grant[1];
    for (int s = 0; s < LAT; s++) begin
      if (bus.flush[pid_d[s]]) pv_d[s] = 1'b0;
    end
  end

  assign exit_hit = pv_q[LAT-1] ? (pid_q[LAT-1] ? 2'b10 : 2'b01) : 2'b00;
  assign push     = exit_hit & ~bus.flush;
  assign pop      = rsp_v & bus.rsp_ready;

  always_comb begin
    infl_d = infl_q;
    for (int r = 0; r < NREQ; r++) begin
      if (bus.flush[r]) begin
        infl_d[r] = '0;
      end else if (grant[r] && !exit_hit[r]) begin
        infl_d[r] = infl_q[r] + 1'b1;
      end else if (!grant[r] && exit_hit[r]) begin
        infl_d[r] = infl_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
      pv_q   <= '0;
      pid_q  <= '0;
      infl_q <= '0;
    end else begin
      last_q <= last_d;
      pv_q   <= pv_d;
      pid_q  <= pid_d;
      infl_q <= infl_d;
    end
  end

  for (genvar r = 0; r < NREQ; r++) begin : g_queue
    fma_arb_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (DW)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (bus.flush[r]),
      .push_i  (push[r]),
      .din_i   ({bus.fma_flg, bus.fma_res}),
      .pop_i   (pop[r]),
      .dout_o  (dout[r]),
      .valid_o (rsp_v[r]),
      .count_o (qcnt[r])
    );
    assign rsp_res_w[r] = dout[r][FLEN-1:0];
    assign rsp_flg_w[r] = dout[r][DW-1:FLEN];
  end

  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_res   = rsp_res_w;
  assign bus.rsp_flg   = rsp_flg_w;

endmodule
`default_nettype wire

// File: tb/tb_fma_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fma_arb : directed scoreboard bench for fma_arb with a behavioural FMA unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fma_arb;
  import fma_arb_pkg::*;

  localparam int FLEN = 64;
  localparam int LAT  = 4;
  localparam int QD   = 4;
  localparam int DW   = FLEN + FLG_W;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   kk [2];

  logic [DW-1:0]   exp_q0 [$];
  logic [DW-1:0]   exp_q1 [$];
  logic [1:0]      gseq   [$];
  logic [FLEN-1:0] fu_res [LAT];
  logic [4:0]      fu_flg [LAT];

  fma_arb_if #(.FLEN(FLEN)) bus ();

  fma_arb #(
    .FLEN   (FLEN),
    .LAT    (LAT),
    .QDEPTH (QD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [FLEN-1:0] fu_f(input logic [FLEN-1:0] x, input logic [FLEN-1:0] y,
                                           input logic [FLEN-1:0] z, input logic [4:0] c);
    return (x ^ {y[FLEN-6:0], y[FLEN-1:FLEN-5]}) + z + FLEN'(c);
  endfunction

  function automatic logic [4:0] fu_g(input logic [FLEN-1:0] x, input logic [FLEN-1:0] y,
                                      input logic [4:0] c);
    return x[4:0] ^ y[9:5] ^ c;
  endfunction

  // Shared FMA unit: result of whatever is on fma_x/y/z/ctl appears LAT cycles later
  always @(posedge clk) begin
    fu_res[0] <= fu_f(bus.fma_x, bus.fma_y, bus.fma_z, bus.fma_ctl);
    fu_flg[0] <= fu_g(bus.fma_x, bus.fma_y, bus.fma_ctl);
    for (int s = 1; s < LAT; s++) begin
      fu_res[s] <= fu_res[s-1];
      fu_flg[s] <= fu_flg[s-1];
    end
  end
  assign bus.fma_res = fu_res[LAT-1];
  assign bus.fma_flg = fu_flg[LAT-1];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int r);
    logic [31:0] k;
    k = 32'(kk[r]);
    bus.req_x[r]   = {16'h1111 + 16'(r), 16'hA5A5, k};
    bus.req_y[r]   = {k ^ 32'h5A5A_0F0F, 28'h0000_C0D, 4'(r)};
    bus.req_z[r]   = {32'hFEDC_BA98, k + 32'(r) * 32'h100};
    bus.req_ctl[r] = fma_ctl_t'(5'(k * 3 + 32'(r) + 1));
  endtask

  function automatic logic [DW-1:0] exp_of(input int r);
    return {fu_g(bus.req_x[r], bus.req_y[r], bus.req_ctl[r]),
            fu_f(bus.req_x[r], bus.req_y[r], bus.req_z[r], bus.req_ctl[r])};
  endfunction

  task automatic push_exp(input int r);
    if (r == 0) exp_q0.push_back(exp_of(0));
    else        exp_q1.push_back(exp_of(1));
  endtask

  // Holds req_valid for ncyc cycles, logging each transfer into the scoreboard
  task automatic run(input logic [1:0] valid, input int ncyc, output int iss0, output int iss1);
    logic [1:0] adv;
    iss0 = 0;
    iss1 = 0;
    gseq.delete();
    bus.req_valid = valid;
    repeat (ncyc) begin
      @(negedge clk);
      adv = bus.req_ready;
      gseq.push_back(bus.req_ready);
      for (int r = 0; r < 2; r++) begin
        if (adv[r]) push_exp(r);
      end
      if (adv[0]) iss0++;
      if (adv[1]) iss1++;
      tick();
      for (int r = 0; r < 2; r++) begin
        if (adv[r]) begin
          kk[r]++;
          set_ops(r);
        end
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    bus.req_valid = '0;
    bus.rsp_ready = 2'b11;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && g < 100) begin
      tick();
      g++;
    end
    chk(nm, 128'(exp_q0.size() + exp_q1.size()), 0);
    repeat (2) tick();
  endtask

  // Scoreboard monitor: every accepted response must match the oldest expectation
  always @(negedge clk) begin : mon
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    if (reset_n) begin
      for (int r = 0; r < 2; r++) begin
        if (bus.rsp_valid[r] && bus.rsp_ready[r]) begin
          got = {bus.rsp_flg[r], bus.rsp_res[r]};
          if ((r == 0 && exp_q0.size() == 0) || (r == 1 && exp_q1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_unexpected[%0d]: got %0h required none", r, got);
          end else begin
            if (r == 0) want = exp_q0.pop_front();
            else        want = exp_q1.pop_front();
            chk($sformatf("rsp_data[%0d]", r), got, want);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int i0, i1, t0, g;
    logic [FLEN-1:0] fres;

    kk[0] = 0;
    kk[1] = 0;
    set_ops(0);
    set_ops(1);
    bus.flush     = '0;
    bus.rsp_ready = '0;
    bus.req_valid = 2'b11;
    reset_n       = 1'b0;
    repeat (2) tick();

    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_fma_issue", bus.fma_issue, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_res", {bus.rsp_res[1], bus.rsp_res[0]}, 0);
    chk("rst_rsp_flg", {bus.rsp_flg[1], bus.rsp_flg[0]}, 0);
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 2'b11;
    reset_n       = 1'b1;
    tick();

    // Single op: issue in cycle 0, response in cycle LAT+1
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("single_ready", bus.req_ready, 2'b01);
    chk("single_issue", bus.fma_issue, 1);
    chk("single_fma_x", bus.fma_x, {16'h1111, 16'hA5A5, 32'h0});
    chk("single_fma_ctl", bus.fma_ctl, 5'd1);
    push_exp(0);
    tick();
    bus.req_valid = '0;
    kk[0]++;
    set_ops(0);
    fres = '0;
    for (int d = 1; d <= LAT; d++) begin
      @(negedge clk);
      chk("single_early", bus.rsp_valid[0], 0);
      if (d == LAT) fres = bus.fma_res;
    end
    @(negedge clk);
    chk("single_valid", bus.rsp_valid[0], 1);
    chk("single_res", bus.rsp_res[0], fres);
    tick();
    drain("single_drain");

    // Contention: last grant went to 0, so the sequence starts with 1
    run(2'b11, 8, i0, i1);
    chk("cont_total", 128'(i0 + i1), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cont_grant%0d", i), gseq[i], (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    drain("cont_drain");

    // Backpressure on requester 0
    bus.rsp_ready = 2'b10;
    run(2'b01, 12, i0, i1);
    chk("bp_issues", i0, QD);
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("bp_stalled", bus.req_ready[0], 0);
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_head_valid", bus.rsp_valid[0], 1);
    tick();
    bus.rsp_ready = 2'b10;
    run(2'b01, 8, i0, i1);
    chk("bp_one_more", i0, 1);
    drain("bp_drain");

    // Simultaneous push and pop with two results queued
    bus.rsp_ready = 2'b10;
    run(2'b01, 2, i0, i1);
    chk("pp_fill", i0, 2);
    repeat (LAT + 2) tick();
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("pp_third_ready", bus.req_ready[0], 1);
    t0 = cyc;
    if (bus.req_ready[0]) push_exp(0);
    tick();
    bus.req_valid = '0;
    kk[0]++;
    set_ops(0);
    g = 0;
    while (cyc != t0 + LAT && g < 50) begin
      tick();
      g++;
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    chk("pp_pop_valid", bus.rsp_valid[0], 1);
    tick();
    bus.rsp_ready = 2'b10;
    run(2'b01, 8, i0, i1);
    chk("pp_credit", i0, 2);
    drain("pp_drain");

    // Flush of requester 0 with three ops in flight
    bus.rsp_ready = 2'b11;
    run(2'b01, 3, i0, i1);
    chk("fl_pre", i0, 3);
    run(2'b10, 1, i0, i1);
    chk("fl_r1", i1, 1);
    bus.flush     = 2'b01;
    bus.req_valid = 2'b11;
    exp_q0.delete();
    @(negedge clk);
    chk("fl_block", bus.req_ready, 2'b10);
    if (bus.req_ready[1]) push_exp(1);
    tick();
    bus.flush = '0;
    kk[1]++;
    set_ops(1);
    bus.rsp_ready = 2'b10;
    bus.req_valid = 2'b01;
    for (int c = 0; c < QD; c++) begin
      @(negedge clk);
      chk("fl_credit", bus.req_ready[0], 1);
      chk("fl_no_rsp0", bus.rsp_valid[0], 0);
      if (bus.req_ready[0]) push_exp(0);
      tick();
      kk[0]++;
      set_ops(0);
    end
    bus.req_valid = '0;
    drain("fl_drain");

    // Reset with ops in flight
    run(2'b11, 3, i0, i1);
    chk("rr_pre", 128'(i0 + i1), 3);
    reset_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    chk("rr_ready", bus.req_ready, 0);
    chk("rr_rsp", bus.rsp_valid, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      chk("rr_no_rsp", bus.rsp_valid, 0);
      tick();
    end
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("rr_tie", bus.req_ready, 2'b01);
    for (int r = 0; r < 2; r++) begin
      if (bus.req_ready[r]) push_exp(r);
    end
    tick();
    bus.req_valid = '0;
    drain("rr_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
